// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response channel between fetch_ctrl and InstrMem.
// One request may be outstanding; ready accepts a request, valid returns its word.
interface fetch_ctrl_if;
   logic        req;
   logic [31:0] addr;
   logic        ready;
   logic        valid;
   logic [31:0] rdata;

   modport master (output req, addr, input ready, valid, rdata);
   modport slave  (input req, addr, output ready, valid, rdata);
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues one instruction-memory request at
// a time, applies branch redirects (squashing an in-flight fetch if needed) and
// holds each fetched word until decode takes it.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                taken,
   input  logic [31:0]         branch_address,
   input  logic                stall,
   fetch_ctrl_if.master        imem,
   output logic [31:0]         pc,
   output logic [31:0]         instr,
   output logic                instr_valid
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] fetch_pc;
   logic [31:0] req_addr;
   logic        squash;
   logic [31:0] target;
   logic        accept;
   logic        deliver;

   // Redirect targets are word aligned.
   assign target  = {branch_address[31:2], 2'b00};
   assign accept  = (state == S_REQ) && imem.ready;
   // A returned word is kept only if it was not squashed earlier and no
   // redirect arrives in the same cycle.
   assign deliver = (state == S_WAIT) && imem.valid && !squash && !taken;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= S_REQ;
      else       state <= state_nxt;
   end

   // Next state: a response in WAIT always ends the outstanding fetch; it only
   // moves to HOLD when the word is kept.
   always_comb begin
      state_nxt = state;
      case (state)
         S_REQ:   if (imem.ready) state_nxt = S_WAIT;
         S_WAIT:  if (imem.valid) state_nxt = deliver ? S_HOLD : S_REQ;
         S_HOLD:  if (taken || !stall) state_nxt = S_REQ;
         default: state_nxt = S_REQ;
      endcase
   end

   // Request outputs: asserted only in REQ and never while reset is applied.
   always_comb begin
      imem.req  = (state == S_REQ) && !reset;
      imem.addr = fetch_pc;
   end

   // Fetch PC, squash flag and the held instruction.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc    <= RESET_PC;
         req_addr    <= RESET_PC;
         squash      <= 1'b0;
         pc          <= RESET_PC;
         instr       <= '0;
         instr_valid <= 1'b0;
      end else begin
         case (state)
            S_REQ: begin
               if (accept) begin
                  req_addr <= fetch_pc;
                  // The old address is already accepted; its data must be dropped.
                  squash   <= taken;
               end
            end
            S_WAIT: begin
               // The response retires the fetch either way; a redirect with no
               // response yet marks the pending word as stale.
               if (imem.valid) squash <= 1'b0;
               else if (taken) squash <= 1'b1;
            end
            S_HOLD: begin
               if (taken || !stall) instr_valid <= 1'b0;
            end
            default: ;
         endcase

         if (deliver) begin
            instr       <= imem.rdata;
            pc          <= req_addr;
            instr_valid <= 1'b1;
         end

         // Redirect beats the sequential increment; the add wraps at 2^32.
         if (taken)        fetch_pc <= target;
         else if (deliver) fetch_pc <= req_addr + PC_STEP;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: a variable-latency memory responder, directed scenarios
// with literal expectations, then randomized traffic checked every cycle
// against an instruction-stream model (next expected PC plus memory image).
module tb_fetch_ctrl;
   localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;
   localparam logic [31:0] STEP   = 32'd4;

   logic        clk = 1'b0;
   logic        reset;
   logic        taken;
   logic [31:0] branch_address;
   logic        stall;
   logic [31:0] pc;
   logic [31:0] instr;
   logic        instr_valid;

   fetch_ctrl_if imem();

   fetch_ctrl #(.RESET_PC(RST_PC), .PC_STEP(STEP)) dut (
      .clk            (clk),
      .reset          (reset),
      .taken          (taken),
      .branch_address (branch_address),
      .stall          (stall),
      .imem           (imem),
      .pc             (pc),
      .instr          (instr),
      .instr_valid    (instr_valid)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Memory image: every address holds a distinct word derived from it.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   // ---------------- memory responder ----------------
   logic        mem_out = 1'b0;
   logic [31:0] mem_addr = '0;
   int          mem_cnt = 0;
   int          lat_min = 1, lat_max = 1;
   bit          ready_rand = 1'b0;
   bit          keep_on_reset = 1'b0;
   int          cyc = 0;
   int          n_ret = 0;
   logic [31:0] acc_q[$];
   int          acc_cyc[$];

   // One clock: sample the handshake before the edge, then update the responder
   // and drive the next cycle's memory inputs.
   task automatic step();
      logic        acc, ret, rst;
      logic [31:0] aaddr;
      @(negedge clk);
      acc   = (imem.req === 1'b1) && (imem.ready === 1'b1) && (reset === 1'b0);
      aaddr = imem.addr;
      ret   = (imem.valid === 1'b1);
      rst   = reset;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
         acc_q.push_back(aaddr);
         acc_cyc.push_back(cyc);
      end
      if (ret) n_ret++;
      if (rst && !keep_on_reset) mem_out = 1'b0;
      if (ret) mem_out = 1'b0;
      if (acc) begin
         mem_out  = 1'b1;
         mem_addr = aaddr;
         mem_cnt  = int'($urandom_range(lat_max - 1, lat_min - 1));
      end
      imem.valid = 1'b0;
      imem.rdata = $urandom;
      if (mem_out) begin
         if (mem_cnt == 0) begin
            imem.valid = 1'b1;
            imem.rdata = mem_word(mem_addr);
         end else mem_cnt--;
      end
      if (ready_rand) imem.ready = ($urandom_range(3, 0) != 0);
   endtask

   task automatic wait_accept(input string name, input logic [31:0] exp);
      int n0 = acc_q.size();
      for (int i = 0; i < 40 && acc_q.size() == n0; i++) step();
      if (acc_q.size() == n0) begin
         n_total++;
         $display("FAIL %s: no request accepted in 40 cycles, expected addr %h", name, exp);
      end else chk(name, acc_q[n0], exp);
   endtask

   task automatic wait_valid(input string name);
      int i;
      for (i = 0; i < 40 && instr_valid !== 1'b1; i++) step();
      if (instr_valid !== 1'b1) begin
         n_total++;
         $display("FAIL %s: instr_valid not seen in 40 cycles", name);
      end
   endtask

   // ---------------- instruction-stream model and per-cycle compare ----------------
   // exp_next is the address of the next instruction decode must see: reset
   // restarts it, a redirect replaces it, a consumption advances it by one word.
   logic [31:0] exp_next  = '0;
   bit          model_on  = 1'b0;
   bit          out_model = 1'b0;
   int          since     = 0;
   int          n_deliv   = 0;

   always @(negedge clk) begin
      if (model_on) begin
         if (instr_valid === 1'b1) begin
            chk("pc", pc, exp_next);
            chk("instr", instr, mem_word(exp_next));
         end else if (instr_valid !== 1'b0) chk("instr_valid_known", instr_valid, 32'd0);
         if (imem.req === 1'b1) chk("imem_addr", imem.addr, exp_next);
         if (out_model) chk("single_outstanding", imem.req, 32'd0);
         if (reset) chk("req_in_reset", imem.req, 32'd0);
         since++;
         if (since > 300) begin
            n_total++;
            $display("FAIL watchdog: no instruction consumed for %0d cycles, expected 300 max", since);
            since = 0;
         end
      end
      if (reset) begin
         exp_next  = RST_PC;
         out_model = 1'b0;
         model_on  = 1'b1;
         since     = 0;
      end else if (model_on) begin
         if (imem.valid === 1'b1) out_model = 1'b0;
         if (imem.req === 1'b1 && imem.ready === 1'b1) out_model = 1'b1;
         if (instr_valid === 1'b1 && !stall && !taken) begin
            n_deliv++;
            since = 0;
         end
         if (taken) exp_next = {branch_address[31:2], 2'b00};
         else if (instr_valid === 1'b1 && !stall) exp_next = exp_next + STEP;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int rets0;
      reset = 1'b1; taken = 1'b0; branch_address = '0; stall = 1'b0;
      imem.ready = 1'b1; imem.valid = 1'b0; imem.rdata = '0;
      step(); step();
      chk("rst_instr_valid", instr_valid, 32'd0);
      chk("rst_pc", pc, RST_PC);
      chk("rst_instr", instr, 32'd0);
      chk("rst_req", imem.req, 32'd0);
      chk("rst_addr", imem.addr, RST_PC);
      reset = 1'b0;
      acc_q.delete(); acc_cyc.delete();

      // Back-to-back fetches, ready always high, 1-cycle memory.
      for (int i = 0; i < 40 && !(instr_valid === 1'b1 && pc === 32'h8); i++) step();
      stall = 1'b1;
      chk("t1_num_acc", acc_q.size(), 32'd4);
      if (acc_q.size() > 0) chk("t1_acc0", acc_q[0], 32'hFFFF_FFFC);
      if (acc_q.size() > 1) chk("t1_acc1_wrap", acc_q[1], 32'h0);
      if (acc_q.size() > 2) chk("t1_acc2", acc_q[2], 32'h4);
      if (acc_q.size() > 3) chk("t1_acc3", acc_q[3], 32'h8);
      if (acc_cyc.size() > 1) chk("t1_req_spacing", acc_cyc[1] - acc_cyc[0], 32'd3);

      // Decode stalls for 5 cycles on the word at 0x8.
      for (int k = 0; k < 5; k++) begin
         step();
         chk("t2_valid", instr_valid, 32'd1);
         chk("t2_pc", pc, 32'h8);
         chk("t2_instr", instr, mem_word(32'h8));
         chk("t2_no_req", imem.req, 32'd0);
      end
      stall = 1'b0; imem.ready = 1'b0;
      step();
      chk("t2_next_req", imem.req, 32'd1);
      chk("t2_next_addr", imem.addr, 32'hC);

      // Redirect in REQ while memory is not ready: the request follows the target.
      taken = 1'b1; branch_address = 32'h4;
      step();
      taken = 1'b0;
      chk("t3_req_redirect_addr", imem.addr, 32'h4);
      chk("t3_req_held", imem.req, 32'd1);
      // Redirect while the 0x4 fetch is in flight with 3-cycle latency.
      lat_min = 3; lat_max = 3; imem.ready = 1'b1;
      wait_accept("t3_acc4", 32'h4);
      taken = 1'b1; branch_address = 32'h100;
      step();
      taken = 1'b0;
      wait_accept("t3_acc100", 32'h100);
      wait_valid("t3_deliver");
      chk("t3_pc", pc, 32'h100);
      chk("t3_instr", instr, mem_word(32'h100));

      // Redirect in HOLD while stalled, unaligned target.
      stall = 1'b1; taken = 1'b1; branch_address = 32'h203;
      step();
      taken = 1'b0;
      chk("t4_dropped", instr_valid, 32'd0);
      stall = 1'b0; lat_min = 1; lat_max = 1;
      wait_accept("t4_acc200", 32'h200);

      // Reset during WAIT; the word arrives after reset and must be ignored.
      lat_min = 4; lat_max = 4; keep_on_reset = 1'b1;
      wait_accept("t6_acc204", 32'h204);
      reset = 1'b1;
      step();
      reset = 1'b0; imem.ready = 1'b0;
      rets0 = n_ret;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("t6_no_valid", instr_valid, 32'd0);
         chk("t6_req", imem.req, 32'd1);
         chk("t6_addr", imem.addr, RST_PC);
      end
      chk("t6_late_word_seen", n_ret - rets0, 32'd1);
      imem.ready = 1'b1; keep_on_reset = 1'b0; lat_min = 1; lat_max = 1;
      wait_accept("t6_first_after_reset", RST_PC);
      wait_valid("t6_deliver");
      chk("t6_pc", pc, RST_PC);
      chk("t6_instr", instr, mem_word(RST_PC));
      wait_accept("t5_wrap", 32'h0);

      // Randomized traffic.
      ready_rand = 1'b1; lat_min = 1; lat_max = 4;
      for (int k = 0; k < 3000; k++) begin
         step();
         taken = ($urandom_range(7, 0) == 0);
         branch_address = ($urandom_range(1, 0) == 0) ? $urandom : {20'h0, 12'($urandom_range(4095, 0))};
         stall = ($urandom_range(2, 0) == 0);
         reset = ($urandom_range(199, 0) == 0);
      end
      reset = 1'b0; taken = 1'b0; stall = 1'b0;
      step();
      chk("random_progress", (n_deliv > 100) ? 32'd1 : 32'd0, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
